// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO status logic: Gray conversions, depth
// derivation and the hysteresis state encodings.
package fifo_pkg;

   localparam int MAX_PTR_WIDTH = 32;

   typedef enum logic {
      AF_IDLE = 1'b0,
      AF_HIGH = 1'b1
   } af_state_e;

   typedef enum logic {
      AE_NORMAL = 1'b0,
      AE_LOW    = 1'b1
   } ae_state_e;

   function automatic int depth_of(input int addrWidth);
      return 2 ** (addrWidth - 1);
   endfunction

   // Narrower pointers are zero-extended; leading zeros stay zero in binary.
   function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] g);
      logic [MAX_PTR_WIDTH-1:0] b;
      b[MAX_PTR_WIDTH-1] = g[MAX_PTR_WIDTH-1];
      for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter for one FIFO pointer.
module gray2bin_conv
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   logic [MAX_PTR_WIDTH-1:0] binWide;

   always_comb begin
      binWide = gray2bin(MAX_PTR_WIDTH'(gray_i));
      bin_o   = binWide[WIDTH-1:0];
   end

endmodule

// File: rtl/fifo_flag_level.sv
// Registered FIFO status generator: empty/full, hysteretic watermarks,
// fill level, peak watermark and sticky illegal-distance error.
module fifo_flag_level
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int AF_SET     = (2 ** (ADDR_WIDTH - 1)) - 4,
   parameter int AF_CLR     = (2 ** (ADDR_WIDTH - 1)) - 8,
   parameter int AE_SET     = 4,
   parameter int AE_CLR     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr_rd,
   input  logic [ADDR_WIDTH-1:0] addr_wr,
   input  logic                  clr_stat,
   output logic                  flag_empty,
   output logic                  flag_full,
   output logic                  flag_almost_empty,
   output logic                  flag_almost_full,
   output logic [ADDR_WIDTH-1:0] level,
   output logic [ADDR_WIDTH-1:0] peak,
   output logic                  err_level
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   localparam logic [ADDR_WIDTH-1:0] DEPTH_L  = ADDR_WIDTH'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] AF_SET_L = ADDR_WIDTH'(AF_SET);
   localparam logic [ADDR_WIDTH-1:0] AF_CLR_L = ADDR_WIDTH'(AF_CLR);
   localparam logic [ADDR_WIDTH-1:0] AE_SET_L = ADDR_WIDTH'(AE_SET);
   localparam logic [ADDR_WIDTH-1:0] AE_CLR_L = ADDR_WIDTH'(AE_CLR);

   if (!(AE_SET >= 0 && AE_SET < AE_CLR && AE_CLR <= DEPTH)) begin : g_badAe
      $error("fifo_flag_level: almost-empty thresholds out of range");
   end
   if (!(AF_CLR >= 0 && AF_CLR < AF_SET && AF_SET <= DEPTH)) begin : g_badAf
      $error("fifo_flag_level: almost-full thresholds out of range");
   end

   logic [ADDR_WIDTH-1:0] rdBin;
   logic [ADDR_WIDTH-1:0] wrBin;

   gray2bin_conv #(.WIDTH(ADDR_WIDTH)) u_rdConv (
      .gray_i (addr_rd),
      .bin_o  (rdBin)
   );

   gray2bin_conv #(.WIDTH(ADDR_WIDTH)) u_wrConv (
      .gray_i (addr_wr),
      .bin_o  (wrBin)
   );

   logic [ADDR_WIDTH-1:0] diff;
   logic                  illegal;
   logic [ADDR_WIDTH-1:0] lvl;

   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   af_state_e             afState_q, afState_d;
   ae_state_e             aeState_q, aeState_d;
   logic [ADDR_WIDTH-1:0] level_q, level_d;
   logic [ADDR_WIDTH-1:0] peak_q, peak_d;
   logic                  err_q, err_d;

   // Modulo subtraction handles pointer wrap; an out-of-range distance is
   // saturated so every downstream comparison sees a full FIFO.
   always_comb begin
      diff    = wrBin - rdBin;
      illegal = (diff > DEPTH_L);
      lvl     = illegal ? DEPTH_L : diff;
   end

   // Next-state: hysteresis resolves directly to whichever side lvl indicates,
   // and a stats clear reloads from the current sample so nothing is lost.
   always_comb begin
      empty_d   = (lvl == '0);
      full_d    = (lvl == DEPTH_L);
      level_d   = lvl;
      afState_d = afState_q;
      aeState_d = aeState_q;
      peak_d    = peak_q;
      err_d     = err_q | illegal;

      if (lvl >= AF_SET_L) begin
         afState_d = AF_HIGH;
      end else if (lvl <= AF_CLR_L) begin
         afState_d = AF_IDLE;
      end

      if (lvl <= AE_SET_L) begin
         aeState_d = AE_LOW;
      end else if (lvl >= AE_CLR_L) begin
         aeState_d = AE_NORMAL;
      end

      if (clr_stat) begin
         peak_d = lvl;
         err_d  = illegal;
      end else if (lvl > peak_q) begin
         peak_d = lvl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         afState_q <= AF_IDLE;
         aeState_q <= AE_LOW;
         level_q   <= '0;
         peak_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         empty_q   <= empty_d;
         full_q    <= full_d;
         afState_q <= afState_d;
         aeState_q <= aeState_d;
         level_q   <= level_d;
         peak_q    <= peak_d;
         err_q     <= err_d;
      end
   end

   assign flag_empty        = empty_q;
   assign flag_full         = full_q;
   assign flag_almost_empty = (aeState_q == AE_LOW);
   assign flag_almost_full  = (afState_q == AF_HIGH);
   assign level             = level_q;
   assign peak              = peak_q;
   assign err_level         = err_q;

endmodule
